// File: rtl/fifo_word_unpacker.sv
// ---------------------------------------------------------------------------
// fifo_word_unpacker
//
// Read-side consumer for a dual-clock FIFO. Words are pulled from the FIFO
// with its pre-set acknowledge protocol, held in a two-entry word buffer and
// emitted as a stream of out_width-bit lanes with a valid/ready handshake.
//
// Parameters
//   in_width   FIFO word width (default 32)
//   out_width  lane width (default 8); in_width must be a multiple of it
//
// Ports
//   clk        FIFO read clock
//   reset_n    asynchronous active-low reset
//   in_data    FIFO read data
//   in_valid   FIFO read-data valid (registered inside the FIFO)
//   in_ack     pre-set acknowledge to the FIFO (pop at the next edge)
//   out_data   current lane
//   out_valid  lane valid
//   out_ready  downstream accepts the lane
//   out_last   current lane is the final lane of its word
//
// Build option
//   WORD_UNPACK_MSB_FIRST_EN  when defined, the most significant lane of each
//                             word is emitted first; otherwise least
//                             significant first.
// ---------------------------------------------------------------------------
module fifo_word_unpacker #(
  parameter int in_width  = 32,
  parameter int out_width = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [in_width-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ack,
  output logic [out_width-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  localparam int LANES  = in_width / out_width;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  if ((in_width % out_width) != 0 || LANES < 1) begin : g_bad_cfg
    $error("fifo_word_unpacker: in_width must be a non-zero multiple of out_width");
  end

  logic [in_width-1:0] word_q [2];
  logic [in_width-1:0] word_d [2];
  logic [1:0]          occ_q, occ_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic                ack_q, ack_d;

  logic                capture;
  logic                lane_fire;
  logic                pop;
  logic [LANE_W-1:0]   lane_sel;
  logic [in_width-1:0] head_word;

  always_comb begin
    // A word is only ours if we acknowledged it at the previous edge; a
    // valid word without that ack is the FIFO showing its head (a peek).
    capture   = in_valid && ack_q;
    out_valid = (occ_q != 2'd0);
    lane_fire = out_valid && out_ready;
    out_last  = out_valid && (lane_q == LAST_LANE);
    pop       = lane_fire && (lane_q == LAST_LANE);

    // Count the word landing this cycle so an ack issued now always has a
    // free slot when its data arrives one cycle later.
    in_ack = reset_n && ((occ_q + {1'b0, capture}) < 2'd2);

    head_word = word_q[rd_ptr_q];
`ifdef WORD_UNPACK_MSB_FIRST_EN
    lane_sel = LAST_LANE - lane_q;
`else
    lane_sel = lane_q;
`endif
    out_data = head_word[lane_sel*out_width +: out_width];

    ack_d    = in_ack;
    word_d   = word_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    lane_d   = lane_q;

    if (capture) begin
      word_d[wr_ptr_q] = in_data;
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (lane_fire) begin
      lane_d = pop ? '0 : lane_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // Simultaneous capture and pop leaves occupancy unchanged.
    case ({capture, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q[0] <= '0;
      word_q[1] <= '0;
      occ_q     <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      lane_q    <= '0;
      ack_q     <= 1'b0;
    end else begin
      word_q[0] <= word_d[0];
      word_q[1] <= word_d[1];
      occ_q     <= occ_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      lane_q    <= lane_d;
      ack_q     <= ack_d;
    end
  end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// ---------------------------------------------------------------------------
// tb_fifo_word_unpacker
//
// Self-checking bench for fifo_word_unpacker. A behavioural FIFO read port
// feeds the 32->8 instance (popping on in_ack, showing its head as a peek
// when not acknowledged). Each pushed word queues its expected lanes on a
// scoreboard that a monitor pops as lanes are accepted. A second instance
// with out_width=32 covers the single-lane configuration.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_word_unpacker;
  localparam int IN_W  = 32;
  localparam int OUT_W = 8;
  localparam int LANES = IN_W / OUT_W;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ack;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  logic [31:0]      s_in_data;
  logic             s_in_valid;
  logic             s_in_ack;
  logic [31:0]      s_out_data;
  logic             s_out_valid;
  logic             s_out_ready;
  logic             s_out_last;

  always #5 clk = ~clk;

  fifo_word_unpacker #(.in_width(IN_W), .out_width(OUT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  fifo_word_unpacker #(.in_width(32), .out_width(32)) dut32 (
    .clk(clk), .reset_n(reset_n),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_ack(s_in_ack),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_last(s_out_last)
  );

  int errors = 0;
  int checks = 0;

  logic [IN_W-1:0]  src_q[$];   // words sitting in the modelled FIFO
  logic [OUT_W:0]   exp_q[$];   // {last, lane} in expected emission order

  bit         mon_en     = 1'b0;
  bit         ready_rand = 1'b0;
  logic       ready_val  = 1'b1;
  int         occ_m      = 0;
  logic       ack_m      = 1'b0;
  int         out_cnt    = 0;
  int         cap_cnt    = 0;
  bit         stall_prev = 1'b0;
  logic [OUT_W:0] stall_val = '0;

  task automatic push_word(input logic [IN_W-1:0] w);
    int idx;
    logic [OUT_W:0] e;
    src_q.push_back(w);
    for (int k = 0; k < LANES; k++) begin
`ifdef WORD_UNPACK_MSB_FIRST_EN
      idx = LANES - 1 - k;
`else
      idx = k;
`endif
      e = {(k == LANES - 1), w[idx*OUT_W +: OUT_W]};
      exp_q.push_back(e);
    end
  endtask

  // FIFO read-port model: pop when acked and non-empty, otherwise show the
  // head unacknowledged (peek) if the FIFO holds something.
  initial begin : fifo_model
    bit pop_dec;
    bit peek_dec;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      pop_dec  = reset_n && in_ack && (src_q.size() != 0);
      peek_dec = reset_n && !in_ack && (src_q.size() != 0);
      @(posedge clk);
      #1;
      if (pop_dec && src_q.size() != 0) begin
        in_data  = src_q.pop_front();
        in_valid = 1'b1;
      end else if (peek_dec && src_q.size() != 0) begin
        in_data  = src_q[0];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Scoreboard monitor: lane order/content, handshake hold, ack rule,
  // occupancy bound.
  initial begin : monitor
    logic           cap;
    logic           pop_e;
    logic           exp_ack;
    logic [OUT_W:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cap     = in_valid && ack_m;
        pop_e   = 1'b0;
        exp_ack = (occ_m + (cap ? 1 : 0)) < 2;
        checks++;
        if (in_ack !== exp_ack) begin
          errors++;
          $display("FAIL in_ack_rule: got %b expected %b occ=%0d t=%0t", in_ack, exp_ack, occ_m, $time);
        end
        checks++;
        if (out_valid !== (occ_m != 0)) begin
          errors++;
          $display("FAIL out_valid_occ: got %b expected %b t=%0t", out_valid, (occ_m != 0), $time);
        end
        if (stall_prev) begin
          checks++;
          if ({out_valid, out_last, out_data} !== {1'b1, stall_val}) begin
            errors++;
            $display("FAIL stall_hold: got v=%b {last,data}=%h expected v=1 %h t=%0t",
                     out_valid, {out_last, out_data}, stall_val, $time);
          end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          checks++;
          out_cnt++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL lane_unexpected: got {last,data}=%h expected none t=%0t", {out_last, out_data}, $time);
          end else begin
            e = exp_q.pop_front();
            pop_e = e[OUT_W];
            if ({out_last, out_data} !== e) begin
              errors++;
              $display("FAIL lane: got {last,data}=%h expected %h t=%0t", {out_last, out_data}, e, $time);
            end
          end
        end
        if (cap) begin
          checks++;
          cap_cnt++;
          if (occ_m == 2 && !pop_e) begin
            errors++;
            $display("FAIL overflow: got capture at occ=2 without pop expected none t=%0t", $time);
          end
        end
        occ_m = occ_m + (cap ? 1 : 0) - (pop_e ? 1 : 0);
        stall_prev = out_valid && !out_ready;
        stall_val  = {out_last, out_data};
      end
      ack_m = in_ack;
    end
  end

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && src_q.size() == 0 && out_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mon_en  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL reset_in_ack: got %b expected 0", in_ack); end
    @(posedge clk); #3;
    reset_n = 1'b1; occ_m = 0; ack_m = 1'b0; stall_prev = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL release_in_ack: got %b expected 1", in_ack); end
  endtask

  task automatic test_single();
    bit ok;
    @(posedge clk); #2;
    push_word(32'h44332211);
    @(posedge clk);               // ack edge t
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency_early: got out_valid=%b expected 0", out_valid); end
    for (int k = 0; k < LANES; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_last !== (k == LANES - 1)) begin
        errors++;
        $display("FAIL single_lane%0d: got valid=%b last=%b expected valid=1 last=%b", k, out_valid, out_last, (k == LANES - 1));
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_after: got out_valid=%b expected 0", out_valid); end
    wait_drain(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_drain: got timeout expected drained"); end
  endtask

  task automatic test_burst();
    bit ok;
    int bubbles;
    int waited;
    @(posedge clk); #2;
    for (int i = 0; i < 8; i++) push_word($urandom);
    waited = 0;
    do begin @(negedge clk); waited++; end while (out_valid !== 1'b1 && waited < 20);
    bubbles = 0;
    for (int i = 1; i < 8 * LANES; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1) bubbles++;
    end
    checks++;
    if (bubbles != 0 || waited >= 20) begin
      errors++; $display("FAIL burst_bubbles: got %0d bubbles (wait %0d) expected 0", bubbles, waited);
    end
    wait_drain(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_drain: got timeout expected drained"); end
  endtask

  task automatic test_peek();
    bit ok;
    int out0;
    int cap0;
    ready_val = 1'b0;
    @(posedge clk); #2;
    out0 = out_cnt; cap0 = cap_cnt;
    for (int i = 0; i < 4; i++) push_word(32'hC0DE0000 + i);
    repeat (12) @(negedge clk);
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL peek_ack: got %b expected 0", in_ack); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL peek_valid: got %b expected 1", out_valid); end
    checks++; if (cap_cnt - cap0 != 2) begin errors++; $display("FAIL peek_captures: got %0d expected 2", cap_cnt - cap0); end
    checks++; if (out_cnt != out0) begin errors++; $display("FAIL peek_stalled: got %0d lanes expected 0", out_cnt - out0); end
    ready_val = 1'b1;
    wait_drain(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL peek_drain: got timeout expected drained"); end
    checks++; if (out_cnt - out0 != 4 * LANES) begin errors++; $display("FAIL peek_lanes: got %0d expected %0d", out_cnt - out0, 4 * LANES); end
    checks++; if (cap_cnt - cap0 != 4) begin errors++; $display("FAIL peek_once: got %0d captures expected 4", cap_cnt - cap0); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int out0;
    out0 = out_cnt;
    ready_rand = 1'b1;
    @(posedge clk); #2;
    for (int i = 0; i < 1000; i++) push_word($urandom);
    wait_drain(20000, ok);
    ready_rand = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: got timeout expected drained"); end
    checks++; if (out_cnt - out0 != 1000 * LANES) begin errors++; $display("FAIL bp_lanes: got %0d expected %0d", out_cnt - out0, 1000 * LANES); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int waited;
    logic [OUT_W-1:0] lane1;
    logic [OUT_W-1:0] first;
`ifdef WORD_UNPACK_MSB_FIRST_EN
    lane1 = 8'hBB; first = 8'h55;
`else
    lane1 = 8'hCC; first = 8'h88;
`endif
    @(posedge clk); #2;
    push_word(32'hAABBCCDD);
    push_word(32'h11223344);
    waited = 0;
    do begin @(negedge clk); waited++; end while (!(out_valid === 1'b1 && out_data === lane1) && waited < 20);
    checks++; if (waited >= 20) begin errors++; $display("FAIL mid_lane1: got timeout expected %h", lane1); end
    @(posedge clk); #3;
    reset_n = 1'b0; mon_en = 1'b0;
    src_q.delete(); exp_q.delete(); in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL mid_out_last: got %b expected 0", out_last); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_out_data: got %h expected 00", out_data); end
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL mid_in_ack: got %b expected 0", in_ack); end
    repeat (2) @(posedge clk);
    @(posedge clk); #3;
    reset_n = 1'b1; occ_m = 0; ack_m = 1'b0; stall_prev = 1'b0; mon_en = 1'b1;
    @(posedge clk); #2;
    push_word(32'h55667788);
    waited = 0;
    do begin @(negedge clk); waited++; end while (out_valid !== 1'b1 && waited < 10);
    checks++;
    if (out_data !== first || waited >= 10) begin
      errors++; $display("FAIL mid_first_lane: got %h expected %h", out_data, first);
    end
    wait_drain(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_drain: got timeout expected drained"); end
  endtask

  task automatic test_single_lane();
    logic [31:0] w[6];
    int nxt;
    int got;
    logic a;
    w = '{32'h44332211, 32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFF, 32'h12345678, 32'h80000000};
    nxt = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      a = s_in_ack;
      if (s_out_valid === 1'b1) begin
        checks++;
        if (s_out_data !== w[got] || s_out_last !== 1'b1) begin
          errors++;
          $display("FAIL lanes1_word%0d: got %h last=%b expected %h last=1", got, s_out_data, s_out_last, w[got]);
        end
        got++;
      end
      @(posedge clk); #1;
      if (a && nxt < 6) begin
        s_in_data = w[nxt]; s_in_valid = 1'b1; nxt++;
      end else begin
        s_in_valid = 1'b0; s_in_data = $urandom;
      end
    end
    s_in_valid = 1'b0;
    checks++; if (got != 6) begin errors++; $display("FAIL lanes1_count: got %0d words expected 6", got); end
    repeat (3) @(negedge clk);
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL lanes1_idle: got %b expected 0", s_out_valid); end
  endtask

  initial begin
    s_in_valid  = 1'b0;
    s_in_data   = '0;
    s_out_ready = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_peek();
    test_backpressure();
    test_reset_mid();
    test_single_lane();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_word_unpacker.md
# fifo_word_unpacker

Read-side consumer for the dual-clock FIFO: accepts `in_width`-bit words using the FIFO's pre-set acknowledge protocol and emits them as a stream of `out_width`-bit lanes with a valid/ready handshake. It sits in the read clock domain, directly downstream of the FIFO. A typical use is unpacking 32-bit bridge words into bytes for core logic. A two-entry word buffer lets a multi-lane configuration sustain one lane per cycle.

## Interface
- `in_width`, default 32: FIFO word width.
- `out_width`, default 8: lane width. `in_width % out_width == 0` is required; `lanes = in_width/out_width` must be ≥1. Elaboration fails otherwise.
- `clk` input, 1 bit: single clock, the FIFO read clock.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `in_data` input, `in_width` bits: FIFO read data.
- `in_valid` input, 1 bit: FIFO read-data valid (registered in the FIFO).
- `in_ack` output, 1 bit: pre-set acknowledge to the FIFO.
- `out_data` output, `out_width` bits: current lane.
- `out_valid` output, 1 bit: lane valid.
- `out_ready` input, 1 bit: downstream accepts the lane.
- `out_last` output, 1 bit: current lane is the final lane of its word.

## Operation
- Input protocol: the FIFO pops an entry at an edge where it is non-empty and `in_ack` is 1. That entry appears on `in_data` with `in_valid`=1 in the following cycle.
- `ack_q` registers `in_ack` each edge.
- Capture condition: a word is captured at an edge iff `in_valid && ack_q`.
- `in_valid` with `ack_q`=0 is a peek. It is ignored, and the FIFO re-presents that entry.
- Buffer: 2-entry word FIFO (`occ` 0..2), head pointer, and lane counter `lane` 0..lanes-1.
- `in_ack = reset_n && ((occ + (in_valid && ack_q)) < 2)`. This guarantees space for any word acked now, counting a word landing this cycle.
- `out_valid = (occ != 0)`.
- `out_data` = head word bits `[lane*out_width +: out_width]`.
- `out_last = out_valid && (lane == lanes-1)`.
- On `out_valid && out_ready`:
  - if `lane == lanes-1`: `lane` becomes 0 and the head entry is popped;
  - otherwise `lane` increments.
- Capture and pop at the same edge: `occ` is unchanged; the write pointer and head pointer both advance, modulo 2.
- Overflow cannot occur by construction. The bench asserts that capture never happens with `occ`==2 unless a pop occurs at the same edge.
- `lanes`==1: `out_last` is always 1 when valid. Throughput is limited to one word per 2 cycles, which is accepted.

## Timing
- Reset (async assert, sync-safe deassert handled by the system):
  - `occ`=0, `lane`=0, `ack_q`=0, pointers=0;
  - `out_valid`=0, `out_last`=0, `out_data`=0, `in_ack`=0 while `reset_n`=0, then 1 in the first cycle after release.
- Latency: `in_ack` high at edge t, then the word is on `in_data` in cycle t+1, captured at edge t+1, and lane 0 has `out_valid` in cycle t+2.
- Steady state, `lanes`≥2 with `out_ready` held 1: one lane per cycle, no bubbles.
- `out_data`, `out_valid` and `out_last` are stable while `out_valid && !out_ready`.
- Reset mid-operation: buffered words and a word acked but not yet captured are discarded. The FIFO read side is reset together with this block.

## Configuration
- `WORD_UNPACK_MSB_FIRST_EN` defined: lane k is taken from bits `[(lanes-1-k)*out_width +: out_width]`, so the most significant lane is emitted first.
- Undefined (default): least significant lane first, as described above.
- `out_last` always marks the final lane emitted, regardless of order.

## Test plan
- Single word 0x44332211, 32 to 8, `out_ready`=1: outputs 0x11, 0x22, 0x33, 0x44 on consecutive cycles, `out_last` only on 0x44, first lane 2 cycles after the ack edge.
- Burst of 8 words, `out_ready`=1: 32 bytes with no idle cycle after the first. `in_ack` never high when (`occ` + landing word) == 2.
- Backpressure: `out_ready` toggled pseudo-randomly for 1000 words: output sequence matches the input order exactly, outputs held stable while stalled, no capture with `ack_q`=0.
- Peek handling: FIFO non-empty with `in_ack` held low by a full buffer: `in_valid`=1 words are not captured and are later delivered exactly once.
- Reset asserted mid-word (after lane 1 of 0xAABBCCDD): all outputs go to 0 immediately, `in_ack`=0. After release, the next word's lane 0 is emitted first.
- `WORD_UNPACK_MSB_FIRST_EN` defined, word 0x44332211: outputs 0x44, 0x33, 0x22, 0x11 with `out_last` on 0x11. With `out_width`=32, each word is emitted with `out_last`=1 at no more than one word per 2 cycles.
